// File: rtl/map_scanner.sv
// Raster-order reader for the game-map tile array: one tile per valid/ready handshake, with row/col.
// Define MAP_SCANNER_CHECKSUM_EN to add a running checksum output over the accepted tiles.
module map_scanner #(
  parameter int DEPTH = 256,
  parameter int COLS  = 16,
  parameter int WIDTH = 5,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ROW_W = ((DEPTH / COLS) > 1) ? $clog2(DEPTH / COLS) : 1,
  localparam int CK_W  = $clog2(DEPTH * ((1 << WIDTH) - 1) + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] stateArray [0:DEPTH-1],
  input  logic             start,
  input  logic             abort,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [WIDTH-1:0] tile_data,
  output logic [ROW_W-1:0] tile_row,
  output logic [COL_W-1:0] tile_col,
  output logic             tile_last,
  output logic             busy,
`ifdef MAP_SCANNER_CHECKSUM_EN
  output logic [CK_W-1:0]  checksum,
`endif
  output logic             done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic             r_vld_p1;
  logic             r_last_p1;
  logic             r_busy;
  logic             r_done;
`ifdef MAP_SCANNER_CHECKSUM_EN
  logic [CK_W-1:0]  r_cksum;
`endif

  logic [IDX_W-1:0] w_next_idx;
  logic             w_accept;
  logic             w_at_last;

  assign w_next_idx = r_idx_p1 + IDX_W'(1);
  assign w_accept   = r_vld_p1 & tile_ready;
  assign w_at_last  = (r_idx_p1 == LAST_IDX);

  // Output register stage: holds the tile currently offered to the consumer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx_p1  <= '0;
      r_data_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MAP_SCANNER_CHECKSUM_EN
      r_cksum   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state   <= SCAN;
            r_idx_p1  <= '0;
            r_data_p1 <= stateArray[0];
            r_vld_p1  <= 1'b1;
            r_last_p1 <= (DEPTH == 1);
            r_busy    <= 1'b1;
`ifdef MAP_SCANNER_CHECKSUM_EN
            r_cksum   <= '0;
`endif
          end
        end
        SCAN: begin
          if (abort) begin
            // Abort beats a same-cycle handshake: that tile is never counted.
            r_state   <= IDLE;
            r_idx_p1  <= '0;
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_busy    <= 1'b0;
          end else if (w_accept) begin
`ifdef MAP_SCANNER_CHECKSUM_EN
            r_cksum <= r_cksum + CK_W'(r_data_p1);
`endif
            if (w_at_last) begin
              r_state   <= IDLE;
              r_idx_p1  <= '0;
              r_vld_p1  <= 1'b0;
              r_last_p1 <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_idx_p1  <= w_next_idx;
              r_data_p1 <= stateArray[w_next_idx];
              r_last_p1 <= (w_next_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tile_valid = r_vld_p1;
  assign tile_data  = r_data_p1;
  assign tile_row   = ROW_W'(int'(r_idx_p1) / COLS);
  assign tile_col   = COL_W'(int'(r_idx_p1) % COLS);
  assign tile_last  = r_last_p1;
  assign busy       = r_busy;
  assign done       = r_done;
`ifdef MAP_SCANNER_CHECKSUM_EN
  assign checksum   = r_cksum;
`endif

endmodule

// File: tb/tb_map_scanner.sv
// Bench for map_scanner: scoreboard of expected tiles plus a checkpoint table and corner-case sequences.
module tb_map_scanner;
  localparam int DEPTH = 256;
  localparam int COLS  = 16;
  localparam int WIDTH = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, start, abort, tile_ready;
  logic [WIDTH-1:0] stateArray [0:DEPTH-1];
  logic             tile_valid, tile_last, busy, done;
  logic [WIDTH-1:0] tile_data;
  logic [3:0]       tile_row, tile_col;
`ifdef MAP_SCANNER_CHECKSUM_EN
  logic [12:0]      checksum;
`endif

  map_scanner #(.DEPTH(DEPTH), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .stateArray(stateArray), .start(start), .abort(abort),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
    .tile_row(tile_row), .tile_col(tile_col), .tile_last(tile_last), .busy(busy),
`ifdef MAP_SCANNER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done)
  );

  typedef struct { int data; int row; int col; int last; } exp_t;
  typedef struct { int idx; int data; int row; int col; int last; } vec_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   img [DEPTH];
  int   cap_data [DEPTH];
  int   cap_row  [DEPTH];
  int   cap_col  [DEPTH];
  int   cap_last [DEPTH];
  int   n_cmp = 0, n_fail = 0;
  int   n_acc = 0, n_done = 0, n_last = 0;
  int   base_acc = 0, base_done = 0, base_last = 0;
  int   cyc;

  function automatic int pat(input int i);
    return (i < 220) ? (i / 20) : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ck(input string name, input int exp);
`ifdef MAP_SCANNER_CHECKSUM_EN
    chk(name, int'(checksum), exp);
`else
    if (exp < 0) $display("note: %s", name);
`endif
  endtask

  // Scoreboard side: runs once per cycle with the inputs that the next edge will sample.
  task automatic mon();
    exp_t e;
    if (done) n_done++;
    if (!reset && tile_valid) begin
      if (sb.size() == 0) begin
        chk("sb_has_entry", 0, 1);
      end else begin
        e = sb[0];
        chk("tile_data", int'(tile_data), e.data);
        chk("tile_row",  int'(tile_row),  e.row);
        chk("tile_col",  int'(tile_col),  e.col);
        chk("tile_last", int'(tile_last), e.last);
        if (tile_ready && !abort) begin
          sb.pop_front();
          if (n_acc - base_acc < DEPTH) begin
            cap_data[n_acc - base_acc] = int'(tile_data);
            cap_row [n_acc - base_acc] = int'(tile_row);
            cap_col [n_acc - base_acc] = int'(tile_col);
            cap_last[n_acc - base_acc] = int'(tile_last);
          end
          n_acc++;
          if (tile_last) n_last++;
        end
      end
    end
  endtask

  task automatic tick();
    mon();
    @(negedge clk);
    #1;
  endtask

  task automatic load_array();
    for (int i = 0; i < DEPTH; i++) stateArray[i] = WIDTH'(pat(i));
  endtask

  task automatic begin_scan(input string name);
    base_acc  = n_acc;
    base_done = n_done;
    base_last = n_last;
    for (int i = 0; i < DEPTH; i++)
      sb.push_back('{img[i], i / COLS, i % COLS, (i == DEPTH - 1) ? 1 : 0});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_first_valid"}, int'(tile_valid), 1);
    chk({name, "_first_busy"},  int'(busy), 1);
    chk({name, "_first_data"},  int'(tile_data), img[0]);
  endtask

  task automatic wait_tile(input int k);
    int b;
    b = 0;
    while (!(tile_valid && (n_acc - base_acc == k)) && b < 2000) begin
      tick();
      b++;
    end
    chk("wait_tile_reached", n_acc - base_acc, k);
  endtask

  task automatic run_to_done(input bit toggle, output int c);
    c = 0;
    while (!done && c < 2000) begin
      tick();
      c++;
      if (toggle) tile_ready = ~tile_ready;
    end
    chk("done_seen", int'(done), 1);
  endtask

  task automatic post_done(input string name);
    tick();
    chk({name, "_done_pulse_1cyc"}, int'(done), 0);
    chk({name, "_valid_after"}, int'(tile_valid), 0);
    chk({name, "_busy_after"}, int'(busy), 0);
    chk({name, "_done_count"}, n_done - base_done, 1);
    chk({name, "_tiles"}, n_acc - base_acc, DEPTH);
    chk({name, "_last_count"}, n_last - base_last, 1);
    chk({name, "_sb_drained"}, sb.size(), 0);
  endtask

  task automatic chk_table(input string name);
    for (int i = 0; i < 7; i++) begin
      chk({name, "_tbl_data"}, cap_data[tbl[i].idx], tbl[i].data);
      chk({name, "_tbl_row"},  cap_row [tbl[i].idx], tbl[i].row);
      chk({name, "_tbl_col"},  cap_col [tbl[i].idx], tbl[i].col);
      chk({name, "_tbl_last"}, cap_last[tbl[i].idx], tbl[i].last);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, int'(tile_valid), 0);
    chk({name, "_data"},  int'(tile_data), 0);
    chk({name, "_row"},   int'(tile_row), 0);
    chk({name, "_col"},   int'(tile_col), 0);
    chk({name, "_last"},  int'(tile_last), 0);
    chk({name, "_busy"},  int'(busy), 0);
    chk({name, "_done"},  int'(done), 0);
  endtask

  initial begin
    tbl[0] = '{0,   0,  0,  0, 0};
    tbl[1] = '{19,  0,  1,  3, 0};
    tbl[2] = '{20,  1,  1,  4, 0};
    tbl[3] = '{100, 5,  6,  4, 0};
    tbl[4] = '{219, 10, 13, 11, 0};
    tbl[5] = '{220, 0,  13, 12, 0};
    tbl[6] = '{255, 0,  15, 15, 1};
    for (int i = 0; i < DEPTH; i++) img[i] = pat(i);

    reset = 1'b1; start = 1'b0; abort = 1'b0; tile_ready = 1'b0;
    load_array();
    repeat (3) tick();
    chk_zero("reset");
    chk_ck("reset_checksum", 0);
    reset = 1'b0;
    tick();
    chk_zero("idle");

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_valid", int'(tile_valid), 0);
    chk("start_abort_busy", int'(busy), 0);
    tick();

    // Full scan, ready held high
    tile_ready = 1'b1;
    begin_scan("scan1");
    run_to_done(1'b0, cyc);
    chk("scan1_cycles", cyc, DEPTH);
    post_done("scan1");
    chk_ck("scan1_checksum", 1100);
    chk_table("scan1");

    // Ready toggling: 0 while tile 0 is first shown, so accepts land on odd cycles
    tile_ready = 1'b0;
    begin_scan("scan2");
    run_to_done(1'b1, cyc);
    chk("scan2_cycles", cyc, 2 * DEPTH);
    tile_ready = 1'b1;
    post_done("scan2");
    chk_ck("scan2_checksum", 1100);
    chk_table("scan2");

    // start mid-scan is ignored
    begin_scan("scan3");
    wait_tile(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(1'b0, cyc);
    post_done("scan3");
    repeat (3) tick();
    chk("scan3_no_restart", int'(tile_valid), 0);
    chk("scan3_single_done", n_done - base_done, 1);

    // abort alongside the handshake of tile 50
    begin_scan("scan4");
    wait_tile(50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", int'(tile_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_tiles", n_acc - base_acc, 50);
    repeat (4) tick();
    chk("abort_no_done", n_done - base_done, 0);
    chk_ck("abort_partial_checksum", 40);
    sb.delete();
    begin_scan("scan5");
    chk("scan5_row", int'(tile_row), 0);
    chk("scan5_col", int'(tile_col), 0);
    run_to_done(1'b0, cyc);
    post_done("scan5");
    chk_ck("scan5_checksum", 1100);

    // reset at tile 130
    begin_scan("scan6");
    wait_tile(130);
    reset = 1'b1;
    tick();
    chk_zero("midreset");
    chk_ck("midreset_checksum", 0);
    reset = 1'b0;
    sb.delete();
    tick();
    chk("midreset_no_done", n_done - base_done, 0);
    begin_scan("scan7");
    run_to_done(1'b0, cyc);
    chk("scan7_cycles", cyc, DEPTH);
    post_done("scan7");

    // array writes during a stall at tile 10
    img[255] = 31;
    begin_scan("scan8");
    wait_tile(10);
    tile_ready = 1'b0;
    stateArray[255] = 5'd31;
    stateArray[10]  = 5'd7;
    repeat (3) tick();
    chk("stall_hold_data", int'(tile_data), 0);
    chk("stall_hold_col", int'(tile_col), 10);
    tile_ready = 1'b1;
    run_to_done(1'b0, cyc);
    post_done("scan8");
    chk("scan8_tile255", cap_data[255], 31);
    chk("scan8_tile10", cap_data[10], 0);
    chk_ck("scan8_checksum", 1131);
    img[255] = 0;
    load_array();

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
